// File: rtl/time_entry.sv
// Keypad time entry and load controller for the microwave timer: gathers MM:SS
// BCD digits, validates on start, then drives the timer digits' load/clear strobes.
module time_entry #(
  parameter int unsigned MAX_MIN_TENS = 9,
  parameter int unsigned MAX_SEC_TENS = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        key_clear,
  input  logic        start,
  input  logic        timer_zero,
  output logic [15:0] data_out,
  output logic        loadn,
  output logic        tclrn,
  output logic        busy,
  output logic        err,
  output logic [2:0]  ndigits
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_LOAD,
    S_RUN
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_buf,   w_buf_nxt;
  logic [2:0]  r_nd,    w_nd_nxt;
  logic        r_loadn, w_loadn_nxt;
  logic        r_tclrn, w_tclrn_nxt;
  logic        r_busy,  w_busy_nxt;
  logic        r_err,   w_err_nxt;

  logic w_digit;
  logic w_entry_ok;

  assign w_digit    = key_valid && (key_code <= 4'd9);
  assign w_entry_ok = (r_buf != '0)
                   && (r_buf[15:12] <= 4'(MAX_MIN_TENS))
                   && (r_buf[7:4]   <= 4'(MAX_SEC_TENS));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_nd    <= '0;
      r_loadn <= 1'b1;
      r_tclrn <= 1'b1;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_buf   <= w_buf_nxt;
      r_nd    <= w_nd_nxt;
      r_loadn <= w_loadn_nxt;
      r_tclrn <= w_tclrn_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_nd_nxt    = r_nd;
    w_tclrn_nxt = 1'b1;
    w_err_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE, S_ENTRY: begin
        if (key_clear) begin
          w_state_nxt = S_IDLE;
          w_buf_nxt   = '0;
          w_nd_nxt    = '0;
        end else if (start) begin
          if (r_state == S_ENTRY && w_entry_ok) w_state_nxt = S_LOAD;
          else                                  w_err_nxt   = 1'b1;
        end else if (w_digit && r_nd < 3'd4) begin
          w_state_nxt = S_ENTRY;
          w_buf_nxt   = {r_buf[11:0], key_code};
          w_nd_nxt    = r_nd + 3'd1;
        end
      end
      S_LOAD: begin
        // timer_zero deliberately not looked at: the timer only now captures data_out
        if (key_clear) begin
          w_state_nxt = S_IDLE;
          w_buf_nxt   = '0;
          w_nd_nxt    = '0;
          w_tclrn_nxt = 1'b0;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (key_clear) begin
          w_state_nxt = S_IDLE;
          w_buf_nxt   = '0;
          w_nd_nxt    = '0;
          w_tclrn_nxt = 1'b0;
        end else if (timer_zero) begin
          w_state_nxt = S_IDLE;
          w_buf_nxt   = '0;
          w_nd_nxt    = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Strobes are derived from the next state so they line up with it as registered outputs
    w_loadn_nxt = (w_state_nxt != S_LOAD);
    w_busy_nxt  = (w_state_nxt == S_RUN);
  end

  assign data_out = r_buf;
  assign ndigits  = r_nd;
  assign loadn    = r_loadn;
  assign tclrn    = r_tclrn;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule

// File: tb/tb_time_entry.sv
// Bench for time_entry: directed vector table, async-reset sequences, and
// randomized traffic checked against a digit-queue reference model.
module tb_time_entry;

  logic        clk = 1'b0;
  logic        clr;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_clear;
  logic        start;
  logic        timer_zero;
  logic [15:0] data_out;
  logic        loadn;
  logic        tclrn;
  logic        busy;
  logic        err;
  logic [2:0]  ndigits;

  int n_vec = 0;
  int n_bad = 0;

  time_entry #(.MAX_MIN_TENS(9), .MAX_SEC_TENS(5)) dut (
    .clk(clk), .clr(clr), .key_valid(key_valid), .key_code(key_code),
    .key_clear(key_clear), .start(start), .timer_zero(timer_zero),
    .data_out(data_out), .loadn(loadn), .tclrn(tclrn), .busy(busy),
    .err(err), .ndigits(ndigits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       kc;
    logic       st;
    logic       kv;
    logic [3:0] code;
    logic       tz;
    logic [15:0] d;
    logic [2:0] nd;
    logic       ln;
    logic       tc;
    logic       bz;
    logic       er;
  } vec_t;

  function automatic vec_t mk(input logic kc, st, kv, input logic [3:0] code,
                              input logic tz, input logic [15:0] d,
                              input logic [2:0] nd, input logic ln, tc, bz, er);
    vec_t v;
    v.kc = kc; v.st = st; v.kv = kv; v.code = code; v.tz = tz;
    v.d = d; v.nd = nd; v.ln = ln; v.tc = tc; v.bz = bz; v.er = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] d, input logic [2:0] nd,
                       input logic ln, tc, bz, er);
    n_vec++;
    if (data_out !== d || ndigits !== nd || loadn !== ln || tclrn !== tc ||
        busy !== bz || err !== er) begin
      n_bad++;
      $display("FAIL %s: got data=%h nd=%0d loadn=%b tclrn=%b busy=%b err=%b, want data=%h nd=%0d loadn=%b tclrn=%b busy=%b err=%b",
               name, data_out, ndigits, loadn, tclrn, busy, err, d, nd, ln, tc, bz, er);
    end
  endtask

  task automatic drive(input logic kc, st, kv, input logic [3:0] code, input logic tz);
    key_clear = kc; start = st; key_valid = kv; key_code = code; timer_zero = tz;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code);
    drive(1'b0, 1'b0, 1'b1, code, 1'b0);
  endtask

  task automatic do_reset();
    #2 clr = 1'b1;
    #1;
    check("reset_immediate", 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3 clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Reference model: the entered digits as a list, plus run/load flags
  int  m_q[$];
  bit  m_running, m_loading;
  logic m_err, m_tclrn;

  function automatic logic [15:0] m_pack();
    int v = 0;
    foreach (m_q[i]) v = v * 16 + m_q[i];
    return 16'(v);
  endfunction

  task automatic m_step(input logic kc, st, kv, input logic [3:0] code, input logic tz);
    int v;
    m_err = 1'b0;
    m_tclrn = 1'b1;
    if (m_loading) begin
      m_loading = 0;
      if (kc) begin m_q.delete(); m_tclrn = 1'b0; end
      else m_running = 1;
    end else if (m_running) begin
      if (kc) begin m_q.delete(); m_running = 0; m_tclrn = 1'b0; end
      else if (tz) begin m_q.delete(); m_running = 0; end
    end else if (kc) begin
      m_q.delete();
    end else if (st) begin
      v = m_pack();
      if (m_q.size() > 0 && v != 0 && (v / 4096) <= 9 && ((v / 16) % 16) <= 5)
        m_loading = 1;
      else
        m_err = 1'b1;
    end else if (kv && code <= 9 && m_q.size() < 4) begin
      m_q.push_back(int'(code));
    end
  endtask

  vec_t tbl[$];

  initial begin
    clr = 1'b1; key_valid = 0; key_code = 0; key_clear = 0; start = 0; timer_zero = 0;
    #1;
    check("power_on_reset", 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    #12 clr = 1'b0;
    @(posedge clk); #1;

    //                 kc st kv code  tz  data     nd  ln tc bz er
    tbl.push_back(mk(0, 0, 1, 4'd1, 0, 16'h0001, 3'd1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd3, 0, 16'h0013, 3'd2, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd0, 0, 16'h0130, 3'd3, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd5, 0, 16'h1305, 3'd4, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd7, 0, 16'h1305, 3'd4, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd12,0, 16'h1305, 3'd4, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'd0, 0, 16'h0000, 3'd0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'd0, 0, 16'h0000, 3'd0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 4'd0, 0, 16'h0000, 3'd0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd2, 0, 16'h0002, 3'd1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd4, 0, 16'h0024, 3'd2, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd5, 0, 16'h0245, 3'd3, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'd0, 0, 16'h0245, 3'd3, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'd0, 0, 16'h0245, 3'd3, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 4'd7, 0, 16'h0245, 3'd3, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'd0, 0, 16'h0245, 3'd3, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 4'd0, 1, 16'h0000, 3'd0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd7, 0, 16'h0007, 3'd1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd5, 0, 16'h0075, 3'd2, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'd0, 0, 16'h0075, 3'd2, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 4'd0, 0, 16'h0075, 3'd2, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'd0, 0, 16'h0000, 3'd0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd3, 0, 16'h0003, 3'd1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd0, 0, 16'h0030, 3'd2, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'd9, 0, 16'h0030, 3'd2, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'd0, 0, 16'h0030, 3'd2, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 4'd1, 0, 16'h0030, 3'd2, 1, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 4'd0, 0, 16'h0000, 3'd0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'd0, 0, 16'h0000, 3'd0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd4, 0, 16'h0004, 3'd1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 4'd0, 0, 16'h0000, 3'd0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd0, 0, 16'h0000, 3'd1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'd0, 0, 16'h0000, 3'd1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 4'd9, 0, 16'h0009, 3'd2, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd5, 0, 16'h0095, 3'd3, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd9, 0, 16'h0959, 3'd4, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'd0, 1, 16'h0959, 3'd4, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'd0, 1, 16'h0959, 3'd4, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 4'd0, 1, 16'h0000, 3'd0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'd1, 0, 16'h0001, 3'd1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'd0, 0, 16'h0001, 3'd1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'd0, 0, 16'h0000, 3'd0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'd0, 0, 16'h0000, 3'd0, 1, 1, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].kc, tbl[i].st, tbl[i].kv, tbl[i].code, tbl[i].tz);
      check($sformatf("table[%0d]", i), tbl[i].d, tbl[i].nd, tbl[i].ln,
            tbl[i].tc, tbl[i].bz, tbl[i].er);
    end

    // Asynchronous reset in the middle of an entry
    press(4'd1); press(4'd2); press(4'd3);
    check("pre_reset_entry", 16'h0123, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    do_reset();
    check("post_reset_idle", 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    press(4'd8);
    check("post_reset_press", 16'h0008, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset while loadn is low
    drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    check("load_before_reset", 16'h0008, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    check("running_before_reset", 16'h0008, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    press(4'd4);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    check("run_to_idle", 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    press(4'd6);
    key_valid = 0; start = 1;
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    check("reset_mid_load", 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    start = 0;
    @(posedge clk);
    #3 clr = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic against the digit-queue model
    m_q.delete(); m_running = 0; m_loading = 0;
    for (int i = 0; i < 3000; i++) begin
      logic kc, st, kv, tz;
      logic [3:0] code;
      kc   = ($urandom_range(0, 19) == 0);
      st   = ($urandom_range(0, 7) == 0);
      kv   = ($urandom_range(0, 1) == 1);
      code = 4'($urandom_range(0, 15));
      tz   = ($urandom_range(0, 5) == 0);
      drive(kc, st, kv, code, tz);
      m_step(kc, st, kv, code, tz);
      check($sformatf("random[%0d]", i), m_pack(), 3'(m_q.size()), !m_loading,
            m_tclrn, m_running, m_err);
    end

    key_valid = 0; key_clear = 0; start = 0; timer_zero = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/time_entry.md
# time_entry

Keypad-side time entry and load controller for the microwave timer. It collects decimal key presses into a 4-digit MM:SS BCD buffer and validates the entry on start. It then drives the cascaded mod-10 timer digits through their parallel-load interface: active-low one-cycle `loadn`, BCD data and active-low clear. It holds off further entry until the timer reports zero or the user cancels.

## Interface
Parameters:
- `MAX_MIN_TENS`, default 9: largest accepted minutes-tens digit.
- `MAX_SEC_TENS`, default 5: largest accepted seconds-tens digit.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `clr`  in  1  asynchronous, active-high reset.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid in this cycle.
- `key_code`  in  4  key value; 0–9 are digits, 10–15 are ignored.
- `key_clear`  in  1  one-cycle cancel/clear request.
- `start`  in  1  one-cycle start request.
- `timer_zero`  in  1  high when all timer digits are zero (AND of the digit `zero` flags).
- `data_out`  out  16  {min_tens, min_units, sec_tens, sec_units}, BCD; feeds the timer digit `data` inputs.
- `loadn`  out  1  active-low parallel-load strobe to the timer digits.
- `tclrn`  out  1  active-low clear strobe to the timer digits.
- `busy`  out  1  high while the timer is running the loaded value.
- `err`  out  1  one-cycle pulse on a rejected start.
- `ndigits`  out  3  number of digits entered, 0–4.

## Operation
- States:
  - IDLE: buffer empty.
  - ENTRY: 1–4 digits held.
  - LOAD: load strobe cycle.
  - RUN: timer running.
- Buffer: 16-bit shift register. A digit press shifts left by one nibble: buffer <= {buffer[11:0], key_code}. `ndigits` increments.
- Press when `ndigits` == 4: buffer full. The digit is dropped and the buffer is unchanged.
- `key_code` > 9: ignored entirely; no state change.
- `data_out` always equals the buffer.
- `start` in ENTRY is valid when both hold:
  - buffer != 0;
  - buffer[15:12] <= MAX_MIN_TENS and buffer[7:4] <= MAX_SEC_TENS.
- Valid start: go to LOAD.
- Invalid start: `err` = 1 for one cycle. Stay in ENTRY with the buffer kept.
- `start` in IDLE: `err` pulse, stay in IDLE.
- LOAD: `loadn` = 0 for exactly this one cycle. Always goes to RUN.
- RUN:
  - `busy` = 1.
  - Digit keys and `start` are ignored.
  - `timer_zero` = 1 → IDLE; buffer cleared, `ndigits` = 0.
- `key_clear`:
  - In IDLE/ENTRY: clears the buffer and `ndigits`, goes to IDLE.
  - In LOAD/RUN: additionally `tclrn` = 0 for one cycle, goes to IDLE.
- Priority within one cycle: `key_clear` > `start` > `key_valid`. A lower-priority event in the same cycle is dropped, not queued.

## Timing
- Reset (`clr` = 1, asynchronous, effective immediately): state IDLE, buffer 0, `data_out` 0, `ndigits` 0, `loadn` 1, `tclrn` 1, `busy` 0, `err` 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Key press at edge N: `data_out` and `ndigits` are updated after edge N.
- Start sampled at edge N: `loadn` low from edge N until edge N+1. The timer captures `data_out` at edge N+1.
- `busy` rises at edge N+1 and remains high until `timer_zero` is sampled high in RUN.
- `timer_zero` is ignored in LOAD. It is first checked in the cycle after LOAD, when the timer already holds the nonzero value.
- `err` and `tclrn` pulses last exactly one cycle.
- `data_out` is stable during LOAD (buffer frozen outside IDLE/ENTRY).
- Reset mid-LOAD: `loadn` returns to 1 immediately. No partial load strobe persists.

## Test plan
- Reset: assert `clr` mid-ENTRY with buffer 0x0123 → all outputs at their reset values immediately; after release, `data_out` = 0, state IDLE.
- Entry and overflow:
  - Stimulus: press 1, 3, 0, 5, then 7.
  - Response: `data_out` = 0x1305, `ndigits` = 4; the 7 is dropped.
  - Also press key 12 → no change.
- Valid start:
  - Stimulus: press 2, 4, 5; `start`.
  - Response: `data_out` = 0x0245; `loadn` low for exactly one cycle one edge after start; `busy` high.
  - Drive `timer_zero` = 1 → IDLE, `data_out` = 0, `busy` 0.
- Rejected starts:
  - Buffer 0x0075 (sec tens 7) with `start` → `err` pulses one cycle, buffer kept, `loadn` stays 1.
  - `start` in IDLE → `err` pulse.
- Cancel in RUN: during RUN pulse `key_clear` → `tclrn` low one cycle, `busy` 0, `data_out` 0; digit presses during RUN before the cancel → no effect.
- Simultaneous events:
  - `start` + `key_valid` (key 9) on buffer 0x0030 → loads 0x0030; the 9 is not appended.
  - `key_clear` + `start` → cleared, no `loadn` pulse.
